// File: rtl/kmeans_regfile_apb.sv
// APB register file for the k-means accelerator: centroids, run configuration,
// indirect sample-RAM writes and the go/busy/done handshake with the core.
module kmeans_regfile_apb #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 91,
  parameter int NUM_CENT = 8,
  parameter int IDX_W    = 4,
  parameter int MAN_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [IDX_W-1:0]  core_idx,
  input  logic              core_we,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              core_done,
  output logic              go_core,
  output logic              irq,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [ADDR_W-1:0] first_addr_o,
  output logic [ADDR_W-1:0] last_addr_o,
  output logic [MAN_W-1:0]  threshold_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} apb_state_t;

  apb_state_t        r_state;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;

  logic              r_busy;
  logic              r_done;
  logic              r_irqEn;
  logic              r_autoinc;
  logic [ADDR_W-1:0] r_ramAddr;
  logic [DATA_W-1:0] r_ramData;
  logic [ADDR_W-1:0] r_first;
  logic [ADDR_W-1:0] r_last;
  logic [MAN_W-1:0]  r_thresh;
  logic [DATA_W-1:0] r_cent [NUM_CENT];
  logic [DATA_W-1:0] r_coreRdata;

  logic              r_ramPend;
  logic              r_ramCsN;
  logic [ADDR_W-1:0] r_ramAddrOut;
  logic [DATA_W-1:0] r_ramDataOut;

  logic              w_commit;
  logic              w_isStatus;
  logic              w_isCtrl;
  logic              w_isRamAddr;
  logic              w_isRamData;
  logic              w_isFirst;
  logic              w_isLast;
  logic              w_isThresh;
  logic              w_centHit;
  logic [3:0]        w_centIdx;
  logic              w_mapped;
  logic              w_locked;
  logic              w_err;
  logic              w_wrOk;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_coreRd;

  assign w_commit    = (r_state == S_SETUP) && psel && penable;
  assign w_isStatus  = (paddr == ADDR_W'(0));
  assign w_isCtrl    = (paddr == ADDR_W'(1));
  assign w_isRamAddr = (paddr == ADDR_W'(2));
  assign w_isRamData = (paddr == ADDR_W'(3));
  assign w_isFirst   = (paddr == ADDR_W'(4));
  assign w_isLast    = (paddr == ADDR_W'(5));
  assign w_isThresh  = (paddr == ADDR_W'(6));
  assign w_centHit   = (paddr >= ADDR_W'(16)) && (paddr < ADDR_W'(16 + NUM_CENT));
  assign w_centIdx   = paddr[3:0];

  // Everything the core consumes during a run is frozen against host writes.
  assign w_locked = w_isRamAddr | w_isRamData | w_isFirst | w_isLast | w_isThresh | w_centHit;
  assign w_err    = !w_mapped | (pwrite & ((w_isStatus & pwdata[0]) | (r_busy & w_locked)));
  assign w_wrOk   = w_commit & pwrite & !w_err;

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    if (w_isStatus)       w_rdata = DATA_W'({r_done, r_busy});
    else if (w_isCtrl)    w_rdata = DATA_W'({r_autoinc, 1'b0, r_irqEn, r_busy});
    else if (w_isRamAddr) w_rdata = DATA_W'(r_ramAddr);
    else if (w_isRamData) w_rdata = r_ramData;
    else if (w_isFirst)   w_rdata = DATA_W'(r_first);
    else if (w_isLast)    w_rdata = DATA_W'(r_last);
    else if (w_isThresh)  w_rdata = DATA_W'(r_thresh);
    else if (w_centHit) begin
      for (int i = 0; i < NUM_CENT; i++) begin
        if (w_centIdx == 4'(i)) w_rdata = r_cent[i];
      end
    end else begin
      w_mapped = 1'b0;
    end
  end

  always_comb begin
    w_coreRd = '0;
    for (int i = 0; i < NUM_CENT; i++) begin
      if (r_busy && core_idx == IDX_W'(i)) w_coreRd = r_cent[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (psel && !penable) r_state <= S_SETUP;
        end
        S_SETUP: begin
          if (psel && penable) begin
            r_state   <= S_ACCESS;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= pwrite ? '0 : w_rdata;
          end else if (!psel) begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // core_done is applied last so it overrides a same-cycle abort or W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_wrOk && w_isCtrl) begin
        if (pwdata[2]) begin
          r_busy <= 1'b0;
        end else if (pwdata[0] && !r_busy) begin
          r_busy <= 1'b1;
          r_done <= 1'b0;
        end
      end
      if (w_wrOk && w_isStatus && pwdata[1]) r_done <= 1'b0;
      if (r_busy && core_done) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irqEn   <= 1'b0;
      r_autoinc <= 1'b0;
      r_ramAddr <= '0;
      r_ramData <= '0;
      r_first   <= '0;
      r_last    <= '0;
      r_thresh  <= '0;
      r_ramPend <= 1'b0;
    end else begin
      r_ramPend <= w_wrOk && w_isRamData;
      if (w_wrOk && w_isCtrl) begin
        r_irqEn   <= pwdata[1];
        r_autoinc <= pwdata[3];
      end
      if (w_wrOk && w_isRamAddr)       r_ramAddr <= pwdata[ADDR_W-1:0];
      else if (r_ramPend && r_autoinc) r_ramAddr <= r_ramAddr + 1'b1;
      if (w_wrOk && w_isRamData) r_ramData <= pwdata;
      if (w_wrOk && w_isFirst)   r_first   <= pwdata[ADDR_W-1:0];
      if (w_wrOk && w_isLast)    r_last    <= pwdata[ADDR_W-1:0];
      if (w_wrOk && w_isThresh)  r_thresh  <= pwdata[MAN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CENT; i++) r_cent[i] <= '0;
      r_coreRdata <= '0;
    end else begin
      r_coreRdata <= w_coreRd;
      for (int i = 0; i < NUM_CENT; i++) begin
        if (w_wrOk && w_centHit && w_centIdx == 4'(i)) r_cent[i] <= pwdata;
        else if (r_busy && core_we && core_idx == IDX_W'(i)) r_cent[i] <= core_wdata;
      end
    end
  end

  // One-cycle RAM write strobe, launched the cycle after the RAM_DATA acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ramCsN     <= 1'b1;
      r_ramAddrOut <= '0;
      r_ramDataOut <= '0;
    end else if (r_ramPend) begin
      r_ramCsN     <= 1'b0;
      r_ramAddrOut <= r_ramAddr;
      r_ramDataOut <= r_ramData;
    end else begin
      r_ramCsN     <= 1'b1;
      r_ramAddrOut <= '0;
      r_ramDataOut <= '0;
    end
  end

  assign prdata       = r_prdata;
  assign pready       = r_pready;
  assign pslverr      = r_pslverr;
  assign core_rdata   = r_coreRdata;
  assign go_core      = r_busy;
  assign irq          = r_done & r_irqEn;
  assign ram_cs_n     = r_ramCsN;
  assign ram_we_n     = r_ramCsN;
  assign ram_addr_o   = r_ramAddrOut;
  assign ram_wdata_o  = r_ramDataOut;
  assign first_addr_o = r_first;
  assign last_addr_o  = r_last;
  assign threshold_o  = r_thresh;

endmodule

// File: doc/kmeans_regfile_apb.md
# kmeans_regfile_apb

Parametrised APB register file for the k-means accelerator. It holds NUM_CENT centroid registers and the run configuration. It performs indirect writes into the sample RAM, with optional address auto-increment. It hands control to the k-means core through a go/busy/done protocol with interrupt. It sits between the APB host and the core/RAM, replacing the fixed 8-centroid register file, and adds error reporting, host reads during a run, and run abort.

## Interface
- ADDR_W, 9: RAM address width; also the paddr width.
- DATA_W, 91: data word width (centroid, RAM data, pwdata/prdata).
- NUM_CENT, 8: number of centroid registers, 1..16.
- IDX_W, 4: core register-index width.
- MAN_W, 16: threshold width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- psel, penable, pwrite  in  1  APB control.
- paddr  in  ADDR_W  APB word address.
- pwdata  in  DATA_W  APB write data.
- prdata  out  DATA_W  APB read data, registered.
- pready  out  1  APB ready, registered.
- pslverr  out  1  APB error, valid with pready.
- core_idx  in  IDX_W  centroid index for core access.
- core_we  in  1  core write strobe.
- core_wdata  in  DATA_W  core write data.
- core_rdata  out  DATA_W  centroid[core_idx], registered.
- core_done  in  1  one-cycle end-of-run pulse.
- go_core  out  1  run active (equals busy).
- irq  out  1  done & irq_en.
- ram_cs_n, ram_we_n  out  1  RAM strobes, active-low.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  DATA_W  RAM write data.
- first_addr_o, last_addr_o  out  ADDR_W  run address range.
- threshold_o  out  MAN_W  convergence threshold.

## Operation
- Register map (word addresses):
  - 0x00 STATUS: bit0 busy (RO), bit1 done (W1C).
  - 0x01 CTRL: bit0 go (W1S, reads busy), bit1 irq_en, bit2 abort (W1, reads 0), bit3 autoinc.
  - 0x02 RAM_ADDR.
  - 0x03 RAM_DATA.
  - 0x04 FIRST.
  - 0x05 LAST.
  - 0x06 THRESH.
  - 0x10+i CENT[i], for i < NUM_CENT.
- Reads return values zero-extended to DATA_W. Writes truncate to the register width.
- APB FSM states:
  - IDLE -> SETUP on psel & !penable.
  - SETUP -> ACCESS on psel & penable. Register update, prdata and pslverr are all registered on this edge, and pready<=1.
  - ACCESS -> IDLE unconditionally, with pready<=0.
  - Every transfer has exactly one wait state.
- pslverr=1, and the write is dropped, in these cases:
  - unmapped address;
  - write to STATUS bit0;
  - write to CENT, RAM_ADDR, RAM_DATA, FIRST, LAST or THRESH while busy.
- Reads are always allowed. An unmapped read returns prdata=0 with pslverr=1.
- Go: a CTRL write with bit0=1 while idle sets busy and clears done. A go while busy is ignored, with no error.
- Done: core_done while busy clears busy and sets done. core_done while idle is ignored.
- Abort: a CTRL write with bit2=1 clears busy and leaves done unchanged. If core_done arrives in the same cycle, core_done wins and done is set.
- Core access, busy only:
  - core_we with core_idx < NUM_CENT writes CENT[core_idx]; otherwise the write is ignored.
  - core_rdata <= CENT[core_idx] each cycle. It is 0 when core_idx >= NUM_CENT or when idle.
- RAM write, on an accepted RAM_DATA write:
  - Next cycle: ram_cs_n=ram_we_n=0 for exactly one cycle, ram_addr_o=RAM_ADDR, ram_wdata_o=RAM_DATA.
  - If autoinc=1, RAM_ADDR increments by 1 in the same cycle, wrapping from 2^ADDR_W-1 to 0.
  - Outside strobe cycles, ram_addr_o and ram_wdata_o are held at 0.
- first_addr_o, last_addr_o and threshold_o continuously reflect their registers.

## Timing
- Reset values: all registers 0; prdata=0, pready=0, pslverr=0, core_rdata=0, go_core=0, irq=0; ram_cs_n=ram_we_n=1; ram_addr_o=ram_wdata_o=0.
- APB: the slave samples SETUP at edge 0. pready=1 after edge 1 and returns to 0 after edge 2.
- A register write is visible on a read issued immediately afterwards.
- go_core rises one cycle after the GO write edge. It falls on the edge that samples core_done or abort.
- irq changes in the same cycle as done or irq_en.
- The RAM strobe is asserted in the cycle after the RAM_DATA write's pready cycle. Back-to-back RAM_DATA writes produce strobes 3 cycles apart.
- Reset mid-transfer: APB returns to IDLE, busy clears, and any pending RAM strobe is cancelled.

## Test plan
- Reset, then read each mapped register -> all 0, pslverr=0. Read 0x07 -> prdata=0, pslverr=1.
- Write CENT[3]=0x5A5A, FIRST=0x010, LAST=0x1FF, THRESH=0x0040 -> read-backs match; first_addr_o=0x010, threshold_o=0x0040.
- With autoinc=1, RAM_ADDR=0x1FE, then RAM_DATA=A and RAM_DATA=B -> strobes at addresses 0x1FE then 0x1FF. RAM_ADDR reads 0x000 afterwards.
- Set irq_en, then GO -> go_core=1. A CENT[0] write gives pslverr=1 and the value is unchanged. Core writes idx 2=0x77 and idx 9 (ignored). core_done -> go_core=0, done=1, irq=1. CENT[2] reads 0x77. W1C of STATUS bit1 -> irq=0.
- GO, then abort -> busy=0, done=0. GO, then abort in the same cycle as core_done -> done=1.
- Assert rst_n low during the ACCESS phase of a write and during a run -> outputs return to reset values and the register is unchanged.
